// File: rtl/fp_frame_tx.sv
// fp_frame_tx
//   Buffers 8-bit converter results {S, E[2:0], F[3:0]} in a small circular
//   FIFO and sends each one as an 11-bit asynchronous serial frame:
//   start(0), 8 data bits LSB first, even parity, stop(1).
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    converter result present
//   in_s/e/f    sign, exponent, significand of the result
//   in_ready    FIFO can accept a word (depends on fifo_count only)
//   tx          serial line, idle high, registered
//   busy        frame in progress
//   fifo_count  words currently buffered
//   frame_done  one-cycle pulse in the last cycle of each stop bit
module fp_frame_tx #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_s,
  input  logic [2:0]               in_e,
  input  logic [3:0]               in_f,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           parity_bit;

  logic [7:0]     in_byte;
  logic [7:0]     head;
  logic           push;
  logic           pop;

  assign in_byte    = {in_s, in_e, in_f};
  assign head       = mem[rd_ptr];
  assign in_ready   = (count != FULL);
  assign push       = in_valid && in_ready;
  assign fifo_count = count;

  // The FSM takes the head word when it leaves IDLE or when a stop bit ends;
  // both are gated on a non-empty FIFO so a pop can never underflow.
  always_comb begin
    pop = 1'b0;
    if (count != '0) begin
      case (state)
        IDLE:    pop = 1'b1;
        STOP:    pop = (baud_cnt == BAUD_LAST);
        default: pop = 1'b0;
      endcase
    end
  end

  // Storage has no reset; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // tx is loaded with the level of the upcoming bit on each bit boundary, so
  // the line changes on the same edge the state does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shreg      <= head;
            parity_bit <= ^head;
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= PARITY;
              tx    <= parity_bit;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          // Registered pulse: raised one cycle early so it lands on the
          // final stop-bit cycle.
          if (baud_cnt == BAUD_PRE) begin
            frame_done <= 1'b1;
          end
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (pop) begin
              shreg      <= head;
              parity_bit <= ^head;
              state      <= START;
              tx         <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_frame_tx.sv
// tb_fp_frame_tx
//   Randomized and directed stimulus for fp_frame_tx against a frame-level
//   reference model: a queue of accepted bytes plus a position within the
//   current 11-bit frame, from which every output is predicted each cycle.
module tb_fp_frame_tx;

  localparam int D  = 4;
  localparam int B  = 4;
  localparam int FL = 11 * B;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_s;
  logic [2:0] in_e;
  logic [3:0] in_f;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0] q[$];
  bit         active = 1'b0;
  int         pos    = 0;
  logic [7:0] cur    = 8'h00;

  fp_frame_tx #(.DEPTH(D), .BAUD_DIV(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_s       (in_s),
    .in_e       (in_e),
    .in_f       (in_f),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Line level of bit b (0 = start, 1..8 = data LSB first, 9 = parity, 10 = stop).
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0)      return 1'b0;
    else if (b <= 8) return d[b-1];
    else if (b == 9) return ^d;
    else             return 1'b1;
  endfunction

  task automatic drive(input logic v, input logic [7:0] b);
    in_valid = v;
    {in_s, in_e, in_f} = b;
  endtask

  // Advance one clock edge, update the model with the inputs that were
  // present at that edge, then compare every output.
  task automatic step();
    int  pre;
    bit  acc;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      active = 1'b0;
      pos    = 0;
    end else begin
      pre = q.size();
      acc = in_valid && (pre != D);
      if (active) begin
        pos++;
        if (pos == FL) active = 1'b0;
      end
      if (!active && pre > 0) begin
        cur    = q.pop_front();
        active = 1'b1;
        pos    = 0;
      end
      if (acc) q.push_back({in_s, in_e, in_f});
    end
    check("tx",         {31'd0, tx},         {31'd0, active ? frame_bit(cur, pos / B) : 1'b1});
    check("busy",       {31'd0, busy},       {31'd0, active});
    check("fifo_count", {29'd0, fifo_count}, q.size());
    check("in_ready",   {31'd0, in_ready},   {31'd0, q.size() != D});
    check("frame_done", {31'd0, frame_done}, {31'd0, active && pos == FL - 1});
  endtask

  task automatic idle(input int n);
    drive(1'b0, 8'h00);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;

    // reset held two cycles with a word offered
    rst = 1'b1;
    drive(1'b1, 8'hA5);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 8'h00);
    step();

    // single word 0xDC, full frame and return to idle
    drive(1'b1, 8'hDC);
    step();
    idle(50);

    // six consecutive distinct words from idle: five accepted
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h11 * (i + 1)));
      step();
    end
    idle(5 * FL + 10);

    // continuous offers: hits the full-FIFO / stop-end pop edge repeatedly
    for (int i = 0; i < 6 * FL; i++) begin
      drive(1'b1, 8'($urandom));
      step();
    end
    idle(5 * FL + 10);

    // all-zero word
    drive(1'b1, 8'h00);
    step();
    idle(50);

    // reset during data bit 3 with two words queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom));
      step();
    end
    drive(1'b0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (active && pos == (1 + 3) * B + 1) found = 1'b1;
      else step();
    end
    check("wait_data_bit3", {31'd0, found}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    drive(1'b1, 8'($urandom));
    step();
    idle(50);

    // random traffic with occasional resets
    for (int i = 0; i < 1200; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 7) == 0), 8'($urandom));
      step();
    end
    rst = 1'b0;
    idle(5 * FL + 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_frame_tx.md
Name: fp_frame_tx

Overview:
- Downstream consumer of the 12-bit-to-floating-point converter: accepts its 8-bit result {S, E[2:0], F[3:0]} through a valid/ready handshake.
- Buffers results in a small circular FIFO.
- Serializes each result as an asynchronous-serial frame on one output line for the board UART/debug header.
- Lets the converter's samples be logged off-board without stalling the sampling logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- BAUD_DIV, 868, clock cycles per serial bit; >= 2 (868 = 115200 baud at 100 MHz).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  converter result is present.
- in_s  input  1  sign bit.
- in_e  input  3  exponent.
- in_f  input  4  significand.
- in_ready  output  1  FIFO can accept a word.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress (FSM not IDLE).
- fifo_count  output  clog2(DEPTH)+1  words currently buffered.
- frame_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (one clk edge with rst=1):
  - tx=1, busy=0, frame_done=0, fifo_count=0, in_ready=1.
  - Read/write pointers=0, FSM=IDLE, baud counter=0, bit index=0.
  - rst overrides every other input on that edge.
- Packing: byte = {in_s, in_e, in_f}; bit7=S, bits6:4=E, bits3:0=F. No other transformation.
- Push:
  - Occurs on an edge where in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH), derived from count only. When full, in_ready is 0 even if a pop happens the same cycle; no pass-through.
- Pop: FSM reads the head entry and advances the read pointer on the edge it leaves IDLE, or when STOP ends with a non-empty FIFO.
- Pointers wrap modulo DEPTH.
- Count update per edge:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
- Pop never occurs when the FIFO is empty; push never occurs when it is full.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If fifo_count>0, pop into the shift register and go to START.
  - START: tx=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, each held BAUD_DIV cycles. Shift register shifts right at each bit boundary.
  - PARITY: tx = XOR of the 8 data bits (even parity) for BAUD_DIV cycles.
  - STOP: tx=1 for BAUD_DIV cycles. frame_done=1 in its final cycle. On the ending edge: if fifo_count>0, pop and go to START (back-to-back, no idle gap); else go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 within each bit, clears at each bit boundary.
- tx is registered (state-decoded from registers). No combinational path from in_* to tx.
- Timing:
  - Frame length = 11*BAUD_DIV cycles.
  - Latency: word pushed at edge k into an empty FIFO with FSM in IDLE; FSM pops at edge k+1; tx=0 from edge k+1.
  - A push on the same edge as the pop from an otherwise-empty FIFO: the pushed word is queued, not lost.
- Reset mid-frame: frame aborts; tx=1 after that edge; FIFO contents discarded; no frame_done pulse.
- busy = (FSM != IDLE); it stays 1 across back-to-back frames.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> tx=1, in_ready=1, fifo_count=0, busy=0, nothing accepted.
- Single word, BAUD_DIV=4: push S=1, E=101, F=1100 (byte 0xDC) -> tx=0 from next edge for 4 cycles, then 0,0,1,1,1,0,1,1 each 4 cycles, parity 1 (five ones), stop 1. frame_done at cycle 44 after tx fell. busy returns to 0.
- Fill, DEPTH=4, idle start: in_valid high 6 consecutive cycles with distinct words -> 5 accepted (first popped immediately), 6th refused with in_ready=0. fifo_count peaks at 4. Five frames sent in order, back-to-back, 220 cycles total with BAUD_DIV=4, tx never idles between frames.
- Full FIFO with in_valid=1 at the STOP-end pop edge -> no push that edge, count 4->3. in_ready rises next cycle and that word is accepted one edge later.
- Zero word S=0, E=000, F=0000 -> 8 zero data bits, parity bit 0, stop 1.
- Reset during DATA bit 3 of a frame with 2 words queued -> tx=1 next cycle, fifo_count=0, no frame_done. A word pushed after release transmits a correct complete frame.
